switches_debounce_ctrl: RTL and testbench
=========================================

SWITCHES_DEBOUNCE_CTRL -- requirements
Module: switches_debounce_ctrl

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, giving the number of switch inputs; legal range 1..32.
REQ-002 The block SHALL have parameter DEBOUNCE_CYCLES, default 50000, giving the number of consecutive clock cycles a new input level must persist; minimum 1.
REQ-003 The block SHALL have parameter EDGE_MODE, default 2, selecting which edges are captured: 0 rising, 1 falling, 2 both.
REQ-004 iClk  input  1  single system clock; all state is updated on the rising edge.
REQ-005 iReset  input  1  reset, asynchronous and active-high.
REQ-006 iChip_select_n  input  1  bus select, active-low.
REQ-007 iRead_n  input  1  read strobe, active-low.
REQ-008 iWrite_n  input  1  write strobe, active-low.
REQ-009 iAddress  input  2  register select.
REQ-010 iWrite_data  input  32  write data.
REQ-011 iSwitches_data  input  WIDTH  raw, asynchronous switch levels.
REQ-012 oRead_data  output  32  registered read data.
REQ-013 oIrq  output  1  interrupt request, active-high, level.

Function
REQ-014 Each switch bit SHALL pass through a 2-flop synchronizer (sync1, then sync2) before any other use.
REQ-015 Each bit SHALL have a debounced state `stable` and a counter `cnt` of width $clog2(DEBOUNCE_CYCLES+1).
REQ-016 Debounce update rules, applied per bit on each clock edge:
- sync2 == stable: cnt <= 0.
- Otherwise, cnt == DEBOUNCE_CYCLES-1: stable <= sync2 and cnt <= 0.
- Otherwise: cnt <= cnt+1.
REQ-017 Debounce latency consequences:
- An input level first sampled by sync1 at edge k appears in stable at edge k+1+DEBOUNCE_CYCLES.
- Any glitch shorter than DEBOUNCE_CYCLES cycles SHALL leave stable unchanged.
REQ-018 The edge register `edge` (WIDTH bits) SHALL set bit i in the same cycle that stable[i] changes, when the change matches EDGE_MODE:
- 0->1 for mode 0.
- 1->0 for mode 1.
- either direction for mode 2.
REQ-019 The register map SHALL be:
- Address 0: stable, read-only.
- Address 1: edge, read; write-1-to-clear.
- Address 2: mask, read/write, WIDTH bits.
- Address 3: reads 0, writes ignored.
- Bits 31:WIDTH of every read SHALL be 0.
REQ-020 A read SHALL occur when iChip_select_n=0 and iRead_n=0 at a clock edge. oRead_data SHALL take the selected register's pre-edge value at that edge (1-cycle latency). Otherwise oRead_data SHALL hold its value.
REQ-021 A write SHALL occur when iChip_select_n=0, iWrite_n=0 and iRead_n=1. If both strobes are low, the access SHALL be treated as a read only.
REQ-022 If an edge set and a W1C clear hit the same bit in the same cycle, the set SHALL win and the bit SHALL stay 1.
REQ-023 Reading the edge register SHALL NOT clear it.
REQ-024 oIrq SHALL equal the OR of (edge AND mask), driven combinationally from those registers; it SHALL deassert the cycle after the last enabled edge bit is cleared or masked.

Reset
REQ-025 While iReset=1, the following SHALL be 0, asynchronously: sync1, sync2, stable, cnt, edge, mask, oRead_data. oIrq SHALL be 0.
REQ-026 After release, inputs already high SHALL be debounced as a 0->1 change, and edge bits SHALL set per EDGE_MODE.
REQ-027 Reset asserted mid-debounce SHALL discard the count. Reset asserted mid-read SHALL force oRead_data to 0.

Verification (WIDTH=8, DEBOUNCE_CYCLES=4, EDGE_MODE=2 unless stated)
REQ-028 Reset behaviour: iSwitches_data=8'h00, reset released -> oRead_data=0, oIrq=0; read address 0 returns 0.
REQ-029 Clean debounce: bit0 driven 0->1 before edge k -> stable=8'h01 at edge k+5, not before; edge=8'h01; oIrq stays 0 with mask=0.
REQ-030 Glitch rejection: bit3 pulsed high for 3 cycles -> stable and edge stay 0. Bit3 held high for 4 cycles after sync -> stable[3]=1.
REQ-031 Interrupt path:
- Write mask=8'h01, then toggle bit0 -> oIrq=1.
- Write 8'h01 to address 1 -> oIrq=0 the next cycle.
- Read address 1 returns 0.
REQ-032 W1C collision: the clear write is issued on the same edge that stable[0] flips -> edge[0]=1 and oIrq stays 1.
REQ-033 Mode check: EDGE_MODE=0, bit1 goes 1->0 -> edge[1] stays 0. Both strobes low with address 2 -> read occurs and mask is unchanged.

Source files
------------

// File: rtl/switches_debounce_ctrl.sv
// switches_debounce_ctrl: synchronised, debounced switch bank with edge capture,
// interrupt mask and a four-register read/write interface.
module switches_debounce_ctrl #(
    parameter int WIDTH           = 32,
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int EDGE_MODE       = 2
) (
    input  logic             iClk,
    input  logic             iReset,
    input  logic             iChip_select_n,
    input  logic             iRead_n,
    input  logic             iWrite_n,
    input  logic [1:0]       iAddress,
    input  logic [31:0]      iWrite_data,
    input  logic [WIDTH-1:0] iSwitches_data,
    output logic [31:0]      oRead_data,
    output logic             oIrq
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
    logic [WIDTH-1:0] r_sync1, r_sync2, r_stable, r_edge, r_mask;
    logic [CW-1:0]    r_cnt [WIDTH];
    logic [WIDTH-1:0] w_done, w_rise, w_fall, w_set, w_clr;
    logic             w_rd, w_wr, w_unused;
    logic [31:0]      w_rdata;
    // w_done marks bits whose new level has persisted long enough to commit this edge
    always_comb begin
        w_done = '0;
        for (int i = 0; i < WIDTH; i++)
            w_done[i] = (r_sync2[i] != r_stable[i]) && (r_cnt[i] == CNT_LAST);
    end
    assign w_rise   = w_done & r_sync2;
    assign w_fall   = w_done & ~r_sync2;
    assign w_set    = (EDGE_MODE == 0) ? w_rise : (EDGE_MODE == 1) ? w_fall : (w_rise | w_fall);
    assign w_rd     = ~iChip_select_n & ~iRead_n;
    assign w_wr     = ~iChip_select_n & ~iWrite_n & iRead_n;
    assign w_clr    = (w_wr && iAddress == 2'd1) ? iWrite_data[WIDTH-1:0] : '0;
    assign w_rdata  = (iAddress == 2'd0) ? 32'(r_stable) :
                      (iAddress == 2'd1) ? 32'(r_edge)   :
                      (iAddress == 2'd2) ? 32'(r_mask)   : 32'd0;
    assign oIrq     = |(r_edge & r_mask);
    assign w_unused = ^iWrite_data;
    always_ff @(posedge iClk or posedge iReset) begin
        if (iReset) begin
            r_sync1    <= '0;
            r_sync2    <= '0;
            r_stable   <= '0;
            r_edge     <= '0;
            r_mask     <= '0;
            oRead_data <= '0;
            for (int i = 0; i < WIDTH; i++) r_cnt[i] <= '0;
        end else begin
            r_sync1  <= iSwitches_data;
            r_sync2  <= r_sync1;
            r_stable <= r_stable ^ w_done;
            for (int i = 0; i < WIDTH; i++)
                r_cnt[i] <= (r_sync2[i] == r_stable[i] || w_done[i]) ? '0 : r_cnt[i] + 1'b1;
            // a set in the same cycle as a clear wins
            r_edge   <= (r_edge & ~w_clr) | w_set;
            if (w_wr && iAddress == 2'd2) r_mask <= iWrite_data[WIDTH-1:0];
            if (w_rd) oRead_data <= w_rdata;
        end
    end
endmodule

// File: tb/tb_switches_debounce_ctrl.sv
// tb_switches_debounce_ctrl: directed stimulus on a both-edges and a rising-only
// instance, checked every cycle against a sample-history model plus literal reads.
module tb_switches_debounce_ctrl;
    localparam int DC = 4;
    logic        clk = 0, rst = 1, cs_n = 1, rd_n = 1, wr_n = 1;
    logic [1:0]  addr = 0;
    logic [31:0] wdata = 0;
    logic [7:0]  sw = 0;
    logic [31:0] o_rd2, o_rd0;
    logic        irq2, irq0;
    int          n_tests = 0, n_fail = 0;
    logic [7:0]  hist [0:DC];
    logic [7:0]  st_m, mask_m, edge_m [2];
    logic [31:0] rd_m [2];

    always #5 clk = ~clk;

    switches_debounce_ctrl #(.WIDTH(8), .DEBOUNCE_CYCLES(DC), .EDGE_MODE(2)) dut2 (
        .iClk(clk), .iReset(rst), .iChip_select_n(cs_n), .iRead_n(rd_n), .iWrite_n(wr_n),
        .iAddress(addr), .iWrite_data(wdata), .iSwitches_data(sw), .oRead_data(o_rd2), .oIrq(irq2));
    switches_debounce_ctrl #(.WIDTH(8), .DEBOUNCE_CYCLES(DC), .EDGE_MODE(0)) dut0 (
        .iClk(clk), .iReset(rst), .iChip_select_n(cs_n), .iRead_n(rd_n), .iWrite_n(wr_n),
        .iAddress(addr), .iWrite_data(wdata), .iSwitches_data(sw), .oRead_data(o_rd0), .oIrq(irq0));

    // A bit commits when the last DC synchronised samples all disagree with it;
    // hist[j] holds the raw sample taken j+1 edges ago, so hist[1..DC] is that window.
    always @(posedge clk or posedge rst) begin
        logic [7:0] flip, clr;
        if (rst) begin
            st_m = 0; mask_m = 0;
            for (int m = 0; m < 2; m++) begin edge_m[m] = 0; rd_m[m] = 0; end
            for (int j = 0; j <= DC; j++) hist[j] = 0;
        end else begin
            if (!cs_n && !rd_n)
                for (int m = 0; m < 2; m++)
                    rd_m[m] = addr == 0 ? {24'b0, st_m} : addr == 1 ? {24'b0, edge_m[m]} :
                              addr == 2 ? {24'b0, mask_m} : 32'b0;
            flip = 0;
            for (int i = 0; i < 8; i++) begin
                flip[i] = 1'b1;
                for (int j = 1; j <= DC; j++) if (hist[j][i] == st_m[i]) flip[i] = 1'b0;
            end
            clr = (!cs_n && !wr_n && rd_n && addr == 1) ? wdata[7:0] : 8'h00;
            edge_m[0] = (edge_m[0] & ~clr) | flip;
            edge_m[1] = (edge_m[1] & ~clr) | (flip & ~st_m);
            if (!cs_n && !wr_n && rd_n && addr == 2) mask_m = wdata[7:0];
            st_m = st_m ^ flip;
            for (int j = DC; j > 0; j--) hist[j] = hist[j-1];
            hist[0] = sw;
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%h expected=%h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic step();
        @(negedge clk);
        chk("cyc_rd_mode2", o_rd2, rd_m[0]);
        chk("cyc_rd_mode0", o_rd0, rd_m[1]);
        chk("cyc_irq_mode2", {31'b0, irq2}, {31'b0, |(edge_m[0] & mask_m)});
        chk("cyc_irq_mode0", {31'b0, irq0}, {31'b0, |(edge_m[1] & mask_m)});
    endtask

    task automatic idle();
        cs_n = 1; rd_n = 1; wr_n = 1; wdata = 0;
    endtask

    task automatic rd(input logic [1:0] a, input logic [31:0] e2, input logic [31:0] e0, input string nm);
        cs_n = 0; rd_n = 0; wr_n = 1; addr = a;
        step();
        idle();
        chk({nm, "_m2"}, o_rd2, e2);
        chk({nm, "_m0"}, o_rd0, e0);
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        cs_n = 0; rd_n = 1; wr_n = 0; addr = a; wdata = d;
        step();
        idle();
    endtask

    initial begin
        repeat (3) step();
        rst = 0;
        step();
        chk("rst_rd", o_rd2, 0);
        chk("rst_irq", {31'b0, irq2}, 0);
        rd(0, 0, 0, "rst_stable");
        // clean debounce of bit0 while reading stable every cycle
        sw = 8'h01; cs_n = 0; rd_n = 0; addr = 0;
        for (int j = 0; j <= 6; j++) begin
            step();
            chk("debounce_timing", o_rd2, (j == 6) ? 32'h1 : 32'h0);
        end
        idle();
        rd(1, 32'h01, 32'h01, "clean_edge");
        chk("clean_irq_masked", {31'b0, irq2}, 0);
        // 3-sample glitch on bit3 is rejected
        sw = 8'h09;
        repeat (3) step();
        sw = 8'h01;
        repeat (8) step();
        rd(0, 32'h01, 32'h01, "glitch_stable");
        rd(1, 32'h01, 32'h01, "glitch_edge");
        // 4 samples is just enough
        sw = 8'h09;
        repeat (4) step();
        repeat (6) step();
        rd(0, 32'h09, 32'h09, "hold_stable");
        // interrupt path
        wr(1, 32'hFF);
        rd(1, 0, 0, "clear_all");
        wr(2, 32'h01);
        sw = 8'h08;
        repeat (8) step();
        chk("irq_set", {31'b0, irq2}, 1);
        wr(1, 32'h01);
        chk("irq_clr", {31'b0, irq2}, 0);
        rd(1, 0, 0, "edge_after_w1c");
        // clear write lands on the edge where stable[0] rises
        sw = 8'h09;
        repeat (5) step();
        cs_n = 0; rd_n = 1; wr_n = 0; addr = 1; wdata = 32'h01;
        step();
        idle();
        chk("collision_irq", {31'b0, irq2}, 1);
        rd(1, 32'h01, 32'h01, "collision_edge");
        // falling bit1 is ignored by the rising-only instance
        sw = 8'h0B;
        repeat (8) step();
        wr(1, 32'h02);
        sw = 8'h09;
        repeat (8) step();
        rd(1, 32'h03, 32'h01, "mode_fall");
        // both strobes low is a read only
        cs_n = 0; rd_n = 0; wr_n = 0; addr = 2; wdata = 32'h0;
        step();
        idle();
        chk("both_low_rd", o_rd2, 32'h01);
        rd(2, 32'h01, 32'h01, "mask_kept");
        // reset in the middle of a read
        rd(0, 32'h09, 32'h09, "pre_rst");
        cs_n = 0; rd_n = 0; addr = 0;
        #2 rst = 1;
        #1;
        chk("rst_mid_rd", o_rd2, 0);
        chk("rst_mid_irq", {31'b0, irq2}, 0);
        idle();
        repeat (2) step();
        rst = 0;
        repeat (8) step();
        rd(0, 32'h09, 32'h09, "post_rst_stable");
        rd(1, 32'h09, 32'h09, "post_rst_edge");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
